// File: rtl/coverage_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coverage_monitor_pkg
// Description : Shared types and helpers for the coverage stall monitor.
//               - state_e       : monitor FSM states
//               - CAUSE_*       : bit positions inside irq_cause
//               - sat_threshold : base * multiplier, clamped to a counter width
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
package coverage_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FIRED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam int CAUSE_STALL = 0;
  localparam int CAUSE_WD    = 1;

  // The product is formed at twice the operand width so it can never wrap;
  // anything beyond the counter range clamps to the counter's all-ones value,
  // which keeps a huge coverage value from producing a tiny threshold.
  function automatic logic [63:0] sat_threshold(
    input logic [63:0] base,
    input logic [63:0] mult,
    input int unsigned cnt_w
  );
    logic [127:0] prod;
    logic [127:0] lim;
    prod = {64'd0, base} * {64'd0, mult};
    lim  = (128'd1 << cnt_w) - 128'd1;
    if (prod > lim) begin
      return lim[63:0];
    end
    return prod[63:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/coverage_stall_channel.sv
`default_nettype none
// ============================================================================
// Module      : coverage_stall_channel
// Description : One monitored channel: remembers the last coverage value,
//               counts cycles without coverage growth (stall_cnt) and cycles
//               without round completion (wd_cnt), and flags threshold hits.
// Ports       : clock, reset     - sole clock, synchronous active-high reset
//               count_en         - counters may advance this cycle
//               clear_all        - zero counters and resample cov (ack)
//               clear_hit        - zero counters (this channel just fired)
//               cov, done        - channel coverage bus and completion strobe
//               stall_hit/wd_hit - limits reached on current registers
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module coverage_stall_channel
  import coverage_monitor_pkg::*;
#(
  parameter int COV_WIDTH      = 30,
  parameter int CNT_WIDTH      = 32,
  parameter int BASE_WAIT      = 1000,
  parameter int SCALE_SHIFT    = 19,
  parameter int WATCHDOG_LIMIT = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 count_en,
  input  logic                 clear_all,
  input  logic                 clear_hit,
  input  logic [COV_WIDTH-1:0] cov,
  input  logic                 done,
  output logic                 stall_hit,
  output logic                 wd_hit
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [COV_WIDTH-1:0] pre_cov_q, pre_cov_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
  logic [63:0]          mult;
  logic [CNT_WIDTH-1:0] threshold;

  // Threshold follows the live cov value, so a coverage jump that raises the
  // threshold past stall_cnt withdraws a hit in the same cycle.
  assign mult      = 64'(cov >> SCALE_SHIFT) + 64'd1;
  assign threshold = CNT_WIDTH'(sat_threshold(64'(BASE_WAIT), mult, CNT_WIDTH));

  // A completing round always wins over a limit reached in the same cycle.
  assign stall_hit = ~done & (stall_cnt_q >= threshold);
  assign wd_hit    = ~done & (64'(wd_cnt_q) >= 64'(WATCHDOG_LIMIT));

  always_comb begin
    pre_cov_d   = pre_cov_q;
    stall_cnt_d = stall_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    if (clear_all) begin
      pre_cov_d   = cov;
      stall_cnt_d = '0;
      wd_cnt_d    = '0;
    end else if (count_en) begin
      if (done) begin
        pre_cov_d   = cov;
        stall_cnt_d = '0;
        wd_cnt_d    = '0;
      end else if (cov != pre_cov_q) begin
        pre_cov_d   = cov;
        stall_cnt_d = '0;
        wd_cnt_d    = (wd_cnt_q == CNT_MAX) ? wd_cnt_q : wd_cnt_q + CNT_WIDTH'(1);
      end else begin
        stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_WIDTH'(1);
        wd_cnt_d    = (wd_cnt_q == CNT_MAX) ? wd_cnt_q : wd_cnt_q + CNT_WIDTH'(1);
      end
      // A channel that just fired restarts from zero; pre_cov still tracks.
      if (clear_hit) begin
        stall_cnt_d = '0;
        wd_cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cov_q   <= '0;
      stall_cnt_q <= '0;
      wd_cnt_q    <= '0;
    end else begin
      pre_cov_q   <= pre_cov_d;
      stall_cnt_q <= stall_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/coverage_stall_monitor.sv
`default_nettype none
// ============================================================================
// Module      : coverage_stall_monitor
// Description : Watches NUM_CH coverage buses for stalls and watchdog expiry
//               and raises a handshaked interrupt to kick a stuck round.
// Ports       : clock, reset - sole clock, synchronous active-high reset
//               enable       - low freezes counters and suppresses firing
//               cov          - channel c at [c*COV_WIDTH +: COV_WIDTH]
//               done         - per-channel round completion
//               irq_ack      - harness acknowledge (honoured only in FIRED)
//               interrupt    - registered request (level or one-cycle pulse)
//               irq_cause    - bit0 stall, bit1 watchdog
//               irq_ch       - channels that caused the current fire
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module coverage_stall_monitor
  import coverage_monitor_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int COV_WIDTH      = 30,
  parameter int CNT_WIDTH      = 32,
  parameter int BASE_WAIT      = 1000,
  parameter int SCALE_SHIFT    = 19,
  parameter int WATCHDOG_LIMIT = 50000,
  parameter int HOLDOFF        = 16,
  parameter int PULSE_MODE     = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_CH*COV_WIDTH-1:0] cov,
  input  logic [NUM_CH-1:0]           done,
  input  logic                        irq_ack,
  output logic                        interrupt,
  output logic [1:0]                  irq_cause,
  output logic [NUM_CH-1:0]           irq_ch
);

  // HOLDOFF lasts HOLDOFF cycles; a value of 0 still spends the single cycle
  // needed to return to RUN.  The counter holds "cycles remaining minus one".
  localparam int               HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLDOFF > 1) ? HOLD_W'(HOLDOFF - 1) : '0;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                interrupt_q, interrupt_d;
  logic [1:0]          irq_cause_q, irq_cause_d;
  logic [NUM_CH-1:0]   irq_ch_q, irq_ch_d;

  logic [NUM_CH-1:0]   stall_hit;
  logic [NUM_CH-1:0]   wd_hit;
  logic [NUM_CH-1:0]   hit;
  logic                count_en;
  logic                fire;
  logic                clear_all;

  assign hit       = stall_hit | wd_hit;
  assign count_en  = (state_q == ST_RUN) && enable;
  assign fire      = count_en && (|hit);
  // Ack only matters once FIRED is registered, so an ack on the entry edge
  // is naturally ignored.
  assign clear_all = (state_q == ST_FIRED) && irq_ack;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      coverage_stall_channel #(
        .COV_WIDTH      (COV_WIDTH),
        .CNT_WIDTH      (CNT_WIDTH),
        .BASE_WAIT      (BASE_WAIT),
        .SCALE_SHIFT    (SCALE_SHIFT),
        .WATCHDOG_LIMIT (WATCHDOG_LIMIT)
      ) u_ch (
        .clock     (clock),
        .reset     (reset),
        .count_en  (count_en),
        .clear_all (clear_all),
        .clear_hit (fire & hit[c]),
        .cov       (cov[c*COV_WIDTH +: COV_WIDTH]),
        .done      (done[c]),
        .stall_hit (stall_hit[c]),
        .wd_hit    (wd_hit[c])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    irq_cause_d = irq_cause_q;
    irq_ch_d    = irq_ch_q;
    case (state_q)
      ST_RUN: begin
        if (fire) begin
          state_d                  = ST_FIRED;
          irq_ch_d                 = hit;
          irq_cause_d[CAUSE_STALL] = |stall_hit;
          irq_cause_d[CAUSE_WD]    = |wd_hit;
        end
      end
      ST_FIRED: begin
        if (irq_ack) begin
          state_d     = ST_HOLDOFF;
          hold_cnt_d  = HOLD_LOAD;
          irq_ch_d    = '0;
          irq_cause_d = '0;
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    interrupt_d = (PULSE_MODE != 0) ? fire : (state_d == ST_FIRED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      hold_cnt_q  <= '0;
      interrupt_q <= 1'b0;
      irq_cause_q <= '0;
      irq_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      interrupt_q <= interrupt_d;
      irq_cause_q <= irq_cause_d;
      irq_ch_q    <= irq_ch_d;
    end
  end

  assign interrupt = interrupt_q;
  assign irq_cause = irq_cause_q;
  assign irq_ch    = irq_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_coverage_stall_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_coverage_stall_monitor
// Description : Drives a level-mode and a pulse-mode monitor with the same
//               stimulus and compares both against a behavioural model of
//               the monitor rules every cycle.
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_coverage_stall_monitor;

  localparam int NUM_CH   = 2;
  localparam int COV_W    = 10;
  localparam int CNT_W    = 11;
  localparam int BASE     = 40;
  localparam int SH       = 4;
  localparam int WDL      = 1500;
  localparam int HOLD     = 5;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int HOLD_CYC = (HOLD > 1) ? HOLD : 1;

  localparam int PH_HOLD        = 0;
  localparam int PH_ONE_TOGGLE  = 1;
  localparam int PH_ALL_TOGGLE  = 2;
  localparam int PH_DONE_EDGE   = 3;
  localparam int PH_ACK_HELD    = 4;
  localparam int PH_RESET_FIRED = 5;
  localparam int PH_EN_LOW      = 6;
  localparam int PH_RANDOM      = 7;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      enable = 1'b0;
  logic                      irq_ack = 1'b0;
  logic [NUM_CH*COV_W-1:0]   cov = '0;
  logic [NUM_CH-1:0]         done = '0;
  logic                      lvl_irq, pls_irq;
  logic [1:0]                lvl_cause, pls_cause;
  logic [NUM_CH-1:0]         lvl_ch, pls_ch;

  always #5 clock = ~clock;

  coverage_stall_monitor #(
    .NUM_CH(NUM_CH), .COV_WIDTH(COV_W), .CNT_WIDTH(CNT_W), .BASE_WAIT(BASE),
    .SCALE_SHIFT(SH), .WATCHDOG_LIMIT(WDL), .HOLDOFF(HOLD), .PULSE_MODE(0)
  ) u_lvl (
    .clock(clock), .reset(reset), .enable(enable), .cov(cov), .done(done),
    .irq_ack(irq_ack), .interrupt(lvl_irq), .irq_cause(lvl_cause), .irq_ch(lvl_ch)
  );

  coverage_stall_monitor #(
    .NUM_CH(NUM_CH), .COV_WIDTH(COV_W), .CNT_WIDTH(CNT_W), .BASE_WAIT(BASE),
    .SCALE_SHIFT(SH), .WATCHDOG_LIMIT(WDL), .HOLDOFF(HOLD), .PULSE_MODE(1)
  ) u_pls (
    .clock(clock), .reset(reset), .enable(enable), .cov(cov), .done(done),
    .irq_ack(irq_ack), .interrupt(pls_irq), .irq_cause(pls_cause), .irq_ch(pls_ch)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 running, 1 fired (waiting for ack), 2 holding off
  int m_pre[NUM_CH];
  int m_stall[NUM_CH];
  int m_wd[NUM_CH];
  int m_mode = 0;
  int m_hold_left = 0;
  int m_pulse = 0;
  int m_cause = 0;
  int m_ch = 0;
  int cov_v[NUM_CH];
  int ack_wait = 0;
  int fires_seen = 0;

  function automatic int thr_of(input int cv);
    longint t;
    t = longint'(BASE) * longint'((cv >> SH) + 1);
    return (t > longint'(CNT_MAX)) ? CNT_MAX : int'(t);
  endfunction

  function automatic int sat_inc(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  task automatic model_step();
    int hs;
    int hw;
    m_pulse = 0;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_pre[c] = 0; m_stall[c] = 0; m_wd[c] = 0;
      end
      m_mode = 0; m_hold_left = 0; m_cause = 0; m_ch = 0;
      return;
    end
    case (m_mode)
      0: if (enable) begin
        hs = 0; hw = 0;
        for (int c = 0; c < NUM_CH; c++) begin
          if (!done[c]) begin
            if (m_stall[c] >= thr_of(cov_v[c])) hs |= (1 << c);
            if (m_wd[c] >= WDL) hw |= (1 << c);
          end
        end
        for (int c = 0; c < NUM_CH; c++) begin
          if (done[c]) begin
            m_stall[c] = 0; m_wd[c] = 0; m_pre[c] = cov_v[c];
          end else if (cov_v[c] != m_pre[c]) begin
            m_pre[c] = cov_v[c]; m_stall[c] = 0; m_wd[c] = sat_inc(m_wd[c]);
          end else begin
            m_stall[c] = sat_inc(m_stall[c]); m_wd[c] = sat_inc(m_wd[c]);
          end
          if (((hs | hw) >> c) & 1) begin
            m_stall[c] = 0; m_wd[c] = 0;
          end
        end
        if ((hs | hw) != 0) begin
          m_mode  = 1;
          m_pulse = 1;
          m_ch    = hs | hw;
          m_cause = ((hs != 0) ? 1 : 0) | ((hw != 0) ? 2 : 0);
          fires_seen++;
        end
      end
      1: if (irq_ack) begin
        m_mode = 2; m_hold_left = HOLD_CYC; m_ch = 0; m_cause = 0;
        for (int c = 0; c < NUM_CH; c++) begin
          m_stall[c] = 0; m_wd[c] = 0; m_pre[c] = cov_v[c];
        end
      end
      default: begin
        m_hold_left--;
        if (m_hold_left == 0) m_mode = 0;
      end
    endcase
  endtask

  // One clock: present inputs, advance model with the edge, compare after it.
  task automatic tick();
    for (int c = 0; c < NUM_CH; c++) cov[c*COV_W +: COV_W] = COV_W'(cov_v[c]);
    @(posedge clock);
    model_step();
    cyc++;
    #1;
    check_eq("lvl_irq",   int'(lvl_irq),   (m_mode == 1) ? 1 : 0);
    check_eq("lvl_cause", int'(lvl_cause), m_cause);
    check_eq("lvl_ch",    int'(lvl_ch),    m_ch);
    check_eq("pls_irq",   int'(pls_irq),   m_pulse);
    check_eq("pls_cause", int'(pls_cause), m_cause);
    check_eq("pls_ch",    int'(pls_ch),    m_ch);
  endtask

  task automatic auto_ack(input int max_d);
    if (m_mode == 1) begin
      if (ack_wait == 0) begin
        irq_ack  = 1'b1;
        ack_wait = int'($urandom_range(max_d, 0));
      end else begin
        irq_ack = 1'b0;
        ack_wait--;
      end
    end else begin
      irq_ack = 1'b0;
    end
  endtask

  task automatic run_phase(input int mode, input int n_cyc);
    for (int i = 0; i < n_cyc; i++) begin
      reset  = 1'b0;
      enable = 1'b1;
      done   = '0;
      case (mode)
        PH_HOLD: auto_ack(30);
        PH_ONE_TOGGLE: begin
          cov_v[0] = 3 << SH;
          cov_v[1] = cov_v[1] ^ 1;
          auto_ack(5);
        end
        PH_ALL_TOGGLE: begin
          for (int c = 0; c < NUM_CH; c++) cov_v[c] = cov_v[c] ^ 1;
          auto_ack(5);
        end
        PH_DONE_EDGE: begin
          // done lands exactly on the cycle the stall count meets its limit
          for (int c = 0; c < NUM_CH; c++)
            done[c] = (m_stall[c] >= thr_of(cov_v[c])) ? 1'b1 : 1'b0;
          auto_ack(5);
        end
        PH_ACK_HELD: irq_ack = 1'b1;
        PH_RESET_FIRED: begin
          irq_ack = 1'b0;
          reset   = (m_mode == 1) ? 1'b1 : 1'b0;
        end
        PH_EN_LOW: begin
          enable = 1'b0;
          auto_ack(3);
        end
        default: begin
          enable  = ($urandom_range(15, 0) != 0) ? 1'b1 : 1'b0;
          irq_ack = ($urandom_range(3, 0) == 0) ? 1'b1 : 1'b0;
          reset   = ($urandom_range(4999, 0) == 0) ? 1'b1 : 1'b0;
          for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(63, 0) == 0) cov_v[c] = int'($urandom_range(1023, 0));
            done[c] = ($urandom_range(511, 0) == 0) ? 1'b1 : 1'b0;
          end
        end
      endcase
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b1; enable = 1'b0; irq_ack = 1'b0; done = '0;
      tick();
    end
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) cov_v[c] = 0;
    do_reset(3);

    // Both channels held at a small value: stall fire on both.
    for (int c = 0; c < NUM_CH; c++) cov_v[c] = 5;
    run_phase(PH_HOLD, 300);

    // Channel 0 scaled threshold (160), channel 1 keeps moving.
    run_phase(PH_ONE_TOGGLE, 600);

    // Everything moving, no done: watchdog path, ack and holdoff.
    do_reset(1);
    run_phase(PH_ALL_TOGGLE, 3500);

    // done coincident with the stall limit must suppress every fire.
    do_reset(1);
    cov_v[0] = 37; cov_v[1] = 200;
    run_phase(PH_DONE_EDGE, 2000);

    // Ack held high: ignored on the entry edge, taken one cycle later.
    cov_v[0] = 9; cov_v[1] = 9;
    run_phase(PH_ACK_HELD, 300);

    // Reset one cycle into FIRED drops the pending interrupt.
    run_phase(PH_RESET_FIRED, 400);

    // Long disabled stretch: nothing may fire.
    do_reset(1);
    run_phase(PH_EN_LOW, 3000);

    // Random mixture of everything.
    run_phase(PH_RANDOM, 30000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coverage_stall_monitor.md
# coverage_stall_monitor

Multi-channel, parametrised successor to the single-channel coverage watchdog in the fuzzing testbench. Watches N coverage-summary buses (base DUT, variant DUT, …) for progress stalls and per-channel watchdog expiry, and raises a handshaked interrupt that the harness forces onto the core's software-interrupt line to kick a stuck round. Adds per-channel causes, ack/holdoff sequencing, an enable gate, pulse/level modes and saturating arithmetic.

## Interface
- NUM_CH, 2, number of monitored channels (≥1)
- COV_WIDTH, 30, width of each coverage bus
- CNT_WIDTH, 32, width of stall/watchdog counters and thresholds
- BASE_WAIT, 1000, base stall threshold in cycles
- SCALE_SHIFT, 19, right shift applied to cov to form the threshold multiplier
- WATCHDOG_LIMIT, 50000, cycles without done before watchdog fires
- HOLDOFF, 16, cycles counters stay frozen after ack
- PULSE_MODE, 0, 0 = interrupt level until ack; 1 = one-cycle pulse on fire
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  counting enabled; low freezes counters and suppresses firing
- cov  in  NUM_CH*COV_WIDTH  channel c at [c*COV_WIDTH +: COV_WIDTH]
- done  in  NUM_CH  per-channel round completion (tohost bit 0)
- irq_ack  in  1  harness acknowledges interrupt
- interrupt  out  1  registered interrupt request
- irq_cause  out  2  bit0 stall, bit1 watchdog; OR over firing channels
- irq_ch  out  NUM_CH  channels contributing to the current fire

## Operation
- Per channel: pre_cov, stall_cnt, wd_cnt registers; all reset to 0.
- threshold_c = BASE_WAIT * ((cov_c >> SCALE_SHIFT) + 1), computed at 2*CNT_WIDTH, saturated to all-ones of CNT_WIDTH.
- FSM states RUN, FIRED, HOLDOFF; reset → RUN.
- RUN, enable=1, each edge per channel:
  - done_c: stall_cnt, wd_cnt ← 0; pre_cov ← cov_c.
  - else cov_c ≠ pre_cov: pre_cov ← cov_c, stall_cnt ← 0, wd_cnt +1.
  - else stall_cnt +1, wd_cnt +1.
  - Both counters saturate at all-ones, never wrap.
- stall_hit_c = stall_cnt ≥ threshold_c; wd_hit_c = wd_cnt ≥ WATCHDOG_LIMIT; both evaluated on current registers and masked by done_c.
- RUN with any hit and enable=1 → FIRED; latch irq_ch, irq_cause from that cycle's hits; clear counters of hit channels.
- FIRED: counters frozen; cov/done ignored; stays until irq_ack. irq_ack → HOLDOFF, irq_ch/irq_cause ← 0, all counters ← 0, pre_cov ← cov.
- HOLDOFF: counters frozen for HOLDOFF cycles (down-counter), then → RUN. HOLDOFF=0 → RUN on next edge.
- irq_ack outside FIRED ignored.
- enable=0 in RUN: all counters hold, no fire; FIRED/HOLDOFF unaffected.

## Timing
- Reset values: interrupt 0, irq_cause 0, irq_ch 0, state RUN, all counters/pre_cov 0.
- Reset mid-FIRED or mid-HOLDOFF: next edge everything at reset values; pending interrupt dropped.
- Fire latency: interrupt rises on the edge after the one on which a counter reaches its limit (one registered stage).
- Level mode: interrupt = (state == FIRED), falls on the edge sampling irq_ack.
- Pulse mode: interrupt high exactly one cycle on entry to FIRED; FIRED still requires irq_ack.
- irq_ack and FIRED entry on the same edge: ack is ignored, entry wins.
- done_c coincident with hit_c: done wins, no fire from channel c.
- Threshold tracks cov combinationally; a cov jump that raises the threshold above stall_cnt cancels a pending hit.

## Structure
- Package coverage_monitor_pkg: state enum (RUN, FIRED, HOLDOFF), cause bit indices CAUSE_STALL=0, CAUSE_WD=1, saturating threshold function.
- Sub-module coverage_stall_channel: one channel's pre_cov, stall_cnt, wd_cnt, hit outputs, with freeze/clear inputs; generated NUM_CH times. Top holds FSM, holdoff counter, output registers.

## Test plan
- NUM_CH=2, cov0=cov1=5 held, no done → interrupt rises on edge 1001 after reset release; irq_cause=01, irq_ch=11.
- cov0 = 3<<19 held, cov1 toggling → fire after 4000 stall cycles; irq_ch=01, irq_cause=01.
- Both cov toggling every cycle, no done → watchdog fires at 50000; irq_cause=10, irq_ch=11; ack → 16 frozen cycles, then counting resumes from 0.
- done0 asserted on the exact cycle stall_cnt0 reaches 1000 → no interrupt; stall_cnt0 = 0 next edge.
- PULSE_MODE=1 stall fire → interrupt high exactly 1 cycle; no re-fire without irq_ack; ack then 1000 further stall cycles → second pulse.
- Reset asserted one cycle into FIRED → interrupt, irq_cause, irq_ch 0 next edge; enable=0 for 5000 cycles then → no fire.
